pn_lfsr_gen: RTL and testbench

Parametrised pseudo-noise generator built on a linear feedback shift register. Width and polynomial are parameters, and each step is selectable at runtime as Fibonacci or Galois. The block also provides seed loading, lock-up protection, a wrap pulse and a measured sequence period. It sits in the sequential/fsm library as the general PN source for scramblers, BIST pattern generation and test stimulus.

---
 rtl/pn_pkg.sv | 73 +++++++
 rtl/pn_period_cnt.sv | 45 ++++
 rtl/pn_lfsr_gen.sv | 99 +++++++++
 tb/tb_pn_lfsr_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared helpers for the PN generator family: LFSR step functions and
// default primitive tap sets for widths 3..32.
package pn_pkg;

  localparam int unsigned PN_MIN_W = 3;
  localparam int unsigned PN_MAX_W = 32;

  typedef logic [PN_MAX_W-1:0] pn_word_t;

  // Coefficients x^0..x^(W-1) of a primitive polynomial per width; x^W implicit.
  localparam pn_word_t PN_DEFAULT_TAPS [PN_MIN_W:PN_MAX_W] = '{
    32'h0000_0005,  // 3 : x^3+x^2+1
    32'h0000_0003,  // 4 : x^4+x+1
    32'h0000_0005,  // 5 : x^5+x^2+1
    32'h0000_0003,  // 6 : x^6+x+1
    32'h0000_0003,  // 7 : x^7+x+1
    32'h0000_001D,  // 8 : x^8+x^4+x^3+x^2+1
    32'h0000_0011,  // 9 : x^9+x^4+1
    32'h0000_0009,  // 10: x^10+x^3+1
    32'h0000_0005,  // 11: x^11+x^2+1
    32'h0000_0053,  // 12: x^12+x^6+x^4+x+1
    32'h0000_001B,  // 13: x^13+x^4+x^3+x+1
    32'h0000_0443,  // 14: x^14+x^10+x^6+x+1
    32'h0000_0003,  // 15: x^15+x+1
    32'h0000_100B,  // 16: x^16+x^12+x^3+x+1
    32'h0000_0009,  // 17: x^17+x^3+1
    32'h0000_0081,  // 18: x^18+x^7+1
    32'h0000_0027,  // 19: x^19+x^5+x^2+x+1
    32'h0000_0009,  // 20: x^20+x^3+1
    32'h0000_0005,  // 21: x^21+x^2+1
    32'h0000_0003,  // 22: x^22+x+1
    32'h0000_0021,  // 23: x^23+x^5+1
    32'h0000_0087,  // 24: x^24+x^7+x^2+x+1
    32'h0000_0009,  // 25: x^25+x^3+1
    32'h0000_0047,  // 26: x^26+x^6+x^2+x+1
    32'h0000_0027,  // 27: x^27+x^5+x^2+x+1
    32'h0000_0009,  // 28: x^28+x^3+1
    32'h0000_0005,  // 29: x^29+x^2+1
    32'h0080_0007,  // 30: x^30+x^23+x^2+x+1
    32'h0000_0009,  // 31: x^31+x^3+1
    32'h0040_0007   // 32: x^32+x^22+x^2+x+1
  };

  function automatic pn_word_t pn_default_taps(input int unsigned width);
    if (width < PN_MIN_W || width > PN_MAX_W) return '0;
    return PN_DEFAULT_TAPS[width];
  endfunction

  function automatic pn_word_t pn_mask(input int unsigned width);
    if (width >= PN_MAX_W) return '1;
    return (pn_word_t'(1) << width) - pn_word_t'(1);
  endfunction

  // Fibonacci: feedback is the parity of state bits selected by the reversed taps.
  function automatic pn_word_t pn_fib_next(input pn_word_t st, input pn_word_t taps,
                                           input int unsigned width);
    logic fb;
    fb = 1'b0;
    for (int unsigned k = 0; k < PN_MAX_W; k++) begin
      if (k < width && taps[k]) fb = fb ^ st[5'(width - 1 - k)];
    end
    return ((st << 1) | pn_word_t'(fb)) & pn_mask(width);
  endfunction

  // Galois: shift left and fold the outgoing MSB back through the taps.
  function automatic pn_word_t pn_gal_next(input pn_word_t st, input pn_word_t taps,
                                           input int unsigned width);
    logic o;
    o = st[5'(width - 1)];
    return ((st << 1) & pn_mask(width)) ^ ({PN_MAX_W{o}} & taps & pn_mask(width));
  endfunction

endpackage

// File: rtl/pn_period_cnt.sv
// Saturating advance counter; captures the count into period on each wrap.
module pn_period_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             cap,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_plus_c;

  assign cnt_plus_c = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

  // Capture outranks clear and increment; the count never rolls over to zero.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (cap) begin
      period_d = cnt_plus_c;
      cnt_d    = '0;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_plus_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period = period_q;

endmodule

// File: rtl/pn_lfsr_gen.sv
// Runtime-selectable Fibonacci/Galois PN generator with seed load,
// lock-up recovery, wrap pulse and measured sequence period.
module pn_lfsr_gen
  import pn_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             galois,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             load_err,
  output logic             lockup
);

  localparam pn_word_t TAPS_W = pn_word_t'(TAPS);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             lockup_q, lockup_d;
  logic             cnt_clr, cnt_inc;
  logic [WIDTH-1:0] fib_next_c, gal_next_c, step_next_c;

  assign fib_next_c  = WIDTH'(pn_fib_next(pn_word_t'(state_q), TAPS_W, WIDTH));
  assign gal_next_c  = WIDTH'(pn_gal_next(pn_word_t'(state_q), TAPS_W, WIDTH));
  assign step_next_c = galois ? gal_next_c : fib_next_c;

  // Per-cycle priority: load, then lock-up recovery, then advance, else hold.
  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    lockup_d   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (load) begin
      if (seed_in != '0) begin
        state_d = seed_in;
        ref_d   = seed_in;
        cnt_clr = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en && state_q == '0) begin
      state_d  = ref_q;
      lockup_d = 1'b1;
      cnt_clr  = 1'b1;
    end else if (en) begin
      state_d = step_next_c;
      cnt_inc = 1'b1;
      wrap_d  = (step_next_c == ref_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEED;
      ref_q      <= SEED;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      lockup_q   <= lockup_d;
    end
  end

  pn_period_cnt #(
    .WIDTH (WIDTH)
  ) u_period_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cap    (wrap_d),
    .period (period)
  );

  assign state    = state_q;
  assign bit_out  = state_q[WIDTH-1];
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_pn_lfsr_gen.sv
// Directed plus randomized bench for pn_lfsr_gen against a polynomial-arithmetic model.
module tb_pn_lfsr_gen;

  localparam logic [3:0] TB_TAPS = 4'b0011;

  logic       clk = 1'b0;
  logic       reset, en, load, galois;
  logic [3:0] seed_in;
  logic [3:0] state, period;
  logic       bit_out, wrap, load_err, lockup;

  always #5 clk = ~clk;

  pn_lfsr_gen #(
    .WIDTH (4),
    .TAPS  (TB_TAPS),
    .SEED  (4'b0001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .seed_in  (seed_in),
    .galois   (galois),
    .state    (state),
    .bit_out  (bit_out),
    .wrap     (wrap),
    .period   (period),
    .load_err (load_err),
    .lockup   (lockup)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] m_state, m_ref, m_period;
  int         m_cnt;
  logic       e_wrap, e_lerr, e_lock;

  logic [3:0] fib_seq [5] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6};
  logic [3:0] gal_seq [5] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6};

  // Fibonacci step as "shift in the parity of the tapped bits".
  function automatic logic [3:0] fib_ref(input logic [3:0] s);
    int par = 0;
    int v;
    for (int k = 0; k < 4; k++) if (TB_TAPS[k]) par += int'(s[2'(3 - k)]);
    v = (int'(s) * 2) % 16 + par % 2;
    return 4'(v);
  endfunction

  // Galois step as multiplication by x modulo the polynomial.
  function automatic logic [3:0] gal_ref(input logic [3:0] s);
    int v;
    v = int'(s) * 2;
    if (v >= 16) v = v ^ (16 + int'(TB_TAPS));
    return 4'(v);
  endfunction

  task automatic model_reset();
    m_state = 4'h1; m_ref = 4'h1; m_period = 4'h0; m_cnt = 0;
    e_wrap = 1'b0; e_lerr = 1'b0; e_lock = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic l, input logic [3:0] s, input logic g);
    logic [3:0] nxt;
    e_wrap = 1'b0; e_lerr = 1'b0; e_lock = 1'b0;
    if (l) begin
      if (s != 4'h0) begin
        m_state = s; m_ref = s; m_cnt = 0;
      end else begin
        e_lerr = 1'b1;
      end
    end else if (e && m_state == 4'h0) begin
      m_state = m_ref; e_lock = 1'b1; m_cnt = 0;
    end else if (e) begin
      nxt = g ? gal_ref(m_state) : fib_ref(m_state);
      m_cnt++;
      if (nxt == m_ref) begin
        e_wrap = 1'b1;
        m_period = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        m_cnt = 0;
      end
      m_state = nxt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},    32'(state),    32'(m_state));
    chk({tag, ".bit_out"},  32'(bit_out),  32'(m_state[3]));
    chk({tag, ".wrap"},     32'(wrap),     32'(e_wrap));
    chk({tag, ".period"},   32'(period),   32'(m_period));
    chk({tag, ".load_err"}, 32'(load_err), 32'(e_lerr));
    chk({tag, ".lockup"},   32'(lockup),   32'(e_lock));
  endtask

  task automatic cycle(input logic e, input logic l, input logic [3:0] s, input logic g,
                       input string tag);
    @(negedge clk);
    en = e; load = l; seed_in = s; galois = g;
    @(posedge clk);
    model_step(e, l, s, g);
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    reset = 1'b1;
    #1 model_reset();
    check_all("reset_pulse");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int adv;
    logic g;
    reset = 1'b1; en = 1'b0; load = 1'b0; galois = 1'b0; seed_in = 4'h0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fibonacci from reset: directed prefix, wrap on the 15th advance.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, "fib");
      chk("fib_seq", 32'(state), 32'(fib_seq[i]));
    end
    for (int i = 5; i < 15; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0, "fib");
    chk("fib_wrap15", 32'(wrap), 32'd1);
    chk("fib_home", 32'(state), 32'd1);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0, "fib2");
    chk("fib_period", 32'(period), 32'd15);

    // Galois from reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b1, "gal");
      chk("gal_seq", 32'(state), 32'(gal_seq[i]));
    end
    for (int i = 5; i < 30; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1, "gal");
    chk("gal_wrap30", 32'(wrap), 32'd1);
    chk("gal_period", 32'(period), 32'd15);

    // Load 1010 with en high: no advance, then wrap back to 1010.
    cycle(1'b1, 1'b1, 4'hA, 1'b0, "load");
    chk("load_state", 32'(state), 32'hA);
    adv = 0;
    do begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, "load_run");
      adv++;
    end while (!wrap && adv < 20);
    chk("load_wrap_seen", 32'(wrap), 32'd1);
    chk("load_wrap_state", 32'(state), 32'hA);
    chk("load_wrap_adv", 32'(adv), 32'd15);

    // Zero seed is rejected and en ignored.
    cycle(1'b1, 1'b0, 4'h0, 1'b0, "pre_zero");
    cycle(1'b1, 1'b1, 4'h0, 1'b0, "zero_load");
    chk("zero_load_err", 32'(load_err), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0, "after_zero");

    // Upset the register to zero, then recover on the next enabled edge.
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    force dut.state_q = 4'h0;
    #1 release dut.state_q;
    m_state = 4'h0;
    cycle(1'b1, 1'b0, 4'h0, 1'b0, "lockup");
    chk("lockup_pulse", 32'(lockup), 32'd1);
    chk("lockup_state", 32'(state), 32'hA);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, "post_lockup");

    // Asynchronous reset mid-sequence, en held high throughout.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0, "pre_areset");
    @(negedge clk);
    en = 1'b1;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("areset");
    chk("areset_state", 32'(state), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 4'h0, 1'b0);
    #1 check_all("areset_resume");
    chk("areset_first", 32'(state), 32'h2);

    // Randomized traffic with sticky but switching mode.
    g = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) g = ~g;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            4'($urandom_range(0, 15)), g, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
